conv3x3_engine: RTL and testbench
=================================

# conv3x3_engine

Convolution datapath downstream of the byte-stream memory controller. When the controller raises one bit of its `en_conv` one-hot, this block reads the 3x3 kernel from weight memory and slides it over the image in image memory. It computes one valid-mode output pixel per window and writes the results into the result memory selected by that bit. It then returns a one-cycle done pulse to the controller's `convin` input.

## Interface
Parameters:
- `IMG_W`, 28: image width in pixels.
- `IMG_H`, 28: image height in pixels.
- `SHIFT`, 4: arithmetic right shift applied to the accumulator before output clamping.
- `ACC_W`, 20: signed accumulator width; must be ≥ 20.

Ports:
- `clk`  in  1: single clock; all logic on posedge.
- `reset`  in  1: asynchronous, active-low reset.
- `conv_en`  in  3: one-hot start/level from the controller's `en_conv`.
- `conv_done`  out  1: one-cycle done pulse, wired to the controller's `convin`.
- `busy`  out  1: high from start acceptance through the done cycle.
- `img_addr`  out  16: image memory read address.
- `img_rd`  out  1: image read strobe.
- `img_data`  in  8: unsigned pixel; valid 1 cycle after the address/strobe.
- `wgt_addr`  out  4: weight memory read address, 0..8, row-major.
- `wgt_rd`  out  1: weight read strobe.
- `wgt_data`  in  8: signed weight; valid 1 cycle after the address/strobe.
- `res_addr`  out  16: result memory write address.
- `res_data`  out  8: unsigned result byte.
- `res_we`  out  3: one-hot write enable, equal to the latched channel, high for one cycle per result.

## Operation
- **Start condition**
  - Start fires on a rising edge of `|conv_en` while in IDLE.
  - The previous-sample register resets to 1, so a `conv_en` already high when reset releases never starts a run.
  - Channel: the lowest set bit of `conv_en` is latched; it stays fixed for the whole run.
- **States**
  - IDLE: waits for the start condition, then goes to LOADW.
  - LOADW: 10 cycles. Issues `wgt_addr` 0..8 on cycles 0..8 and captures `wgt_data` into `w[0..8]` on cycles 1..9. Then goes to MAC.
  - MAC: 10 cycles per window.
    - Tap k = 0..8 issues `img_addr = (r+k/3)*IMG_W + (c+k%3)` with `img_rd` high.
    - Cycles 1..9 do `acc += $signed({1'b0,img_data}) * w[k-1]`.
    - `acc` clears on cycle 0. Then goes to WRITE.
  - WRITE: 1 cycle. Drives `res_we`, `res_addr = r*(IMG_W-2)+c` and `res_data = clamp(acc >>> SHIFT)`.
    - Advances c; when c wraps at IMG_W-2, c returns to 0 and r increments.
    - Goes to DONE after the last window (r = IMG_H-3, c = IMG_W-3); otherwise back to MAC.
  - DONE: 1 cycle with `conv_done` = 1, then returns to IDLE.
- **Clamp**
  - `>>>` is an arithmetic shift.
  - Negative results give 0 (ReLU); results above 255 give 255; otherwise the low 8 bits.
- **Windows:** N = (IMG_W-2)*(IMG_H-2) windows, in row-major order.
- **Ignored inputs**
  - Further edges or extra bits on `conv_en` while busy are ignored.
  - `conv_en` falling mid-run does not abort the run.
  - A held-high `conv_en` after DONE does not restart; it must fall and rise again.
- **Reset mid-run:** returns immediately to IDLE with all outputs cleared. Result memory contents are then undefined, and no `conv_done` is issued.

## Timing
- **Reset values:** all outputs 0; `r`, `c`, `acc` and the channel register are 0; `w[0..8]` are 0.
- **Start:** let E be the edge where IDLE samples the start condition.
  - LOADW occupies cycles E+1..E+10.
  - Window p occupies E+11+11p .. E+21+11p, with the write on E+21+11p.
- **Done:** `conv_done` is high only on cycle E+11+11N; `busy` is high E+1..E+11+11N.
- **Strobes:** `img_rd` and `wgt_rd` are high only on address-issue cycles. Addresses hold their last value otherwise.
- **Result bus:** `res_addr` and `res_data` are valid only when `res_we` ≠ 0.

## Test plan
Use IMG_W = IMG_H = 4 (N = 4, done at E+55) unless noted.
- **Uniform:** weights all 1, pixels all 16, SHIFT = 4, `conv_en` = 001 → four writes with `res_data` = 9 at `res_addr` 0..3, `res_we` = 001; `conv_done` at E+55.
- **Center tap / address order:** center weight 1, others 0, pixel value = its address, SHIFT = 0 → `res_data` 5, 6, 9, 10 at addresses 0..3.
- **Clamping:**
  - Weights all 127, pixels 255, SHIFT = 0 → all results 255.
  - Weights all -1 → all results 0.
- **Channel select:** `conv_en` = 110 → `res_we` = 010 on every write. `conv_en` held high after done → no second run. A toggle on `conv_en` mid-run → no effect, done still at E+55.
- **Reset mid-MAC:** reset asserted at E+30 → all outputs 0 immediately, no `conv_done`. With `conv_en` still high at release → stays IDLE; a later 0→1 on `conv_en` starts a full run.

Source files
------------

// File: rtl/conv3x3_engine.sv
// conv3x3_engine: 3x3 valid-mode convolution over an image held in a
// sync-read memory. It loads 9 signed weights, then for each window it
// issues 9 pixel reads, accumulates, clamps and writes one byte to the
// result memory chosen by the start channel. It ends with a done pulse.
module conv3x3_engine #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int SHIFT = 4,
  parameter int ACC_W = 20
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  conv_en,
  output logic        conv_done,
  output logic        busy,
  output logic [15:0] img_addr,
  output logic        img_rd,
  input  logic [7:0]  img_data,
  output logic [3:0]  wgt_addr,
  output logic        wgt_rd,
  input  logic [7:0]  wgt_data,
  output logic [15:0] res_addr,
  output logic [7:0]  res_data,
  output logic [2:0]  res_we
);

  typedef enum logic [2:0] {S_IDLE, S_LOADW, S_MAC, S_WRITE, S_DONE} state_t;

  localparam logic signed [ACC_W-1:0] CLAMP_MAX = ACC_W'(255);

  state_t                   r_state, w_next;
  logic [3:0]               r_cnt;
  logic [15:0]              r_row, r_col;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [7:0]        r_w [0:8];
  logic [2:0]               r_ch;
  logic                     r_en_prev;
  logic [15:0]              r_img_addr_q;
  logic [3:0]               r_wgt_addr_q;

  logic                     w_start, w_last, w_cnt_end;
  logic [1:0]               w_roff, w_coff;
  logic [15:0]              w_img_addr;
  logic [3:0]               w_kidx;
  logic signed [8:0]        w_pix;
  logic signed [16:0]       w_prod;
  logic signed [ACC_W-1:0]  w_sh;
  logic [7:0]               w_clamped;

  assign w_start   = (r_state == S_IDLE) && (|conv_en) && !r_en_prev;
  assign w_last    = (r_row == 16'(IMG_H - 3)) && (r_col == 16'(IMG_W - 3));
  assign w_cnt_end = (r_cnt == 4'd9);

  // Tap k -> (row, col) offset inside the 3x3 window, row-major
  always_comb begin
    w_roff = 2'd0;
    w_coff = 2'd0;
    case (r_cnt)
      4'd1: w_coff = 2'd1;
      4'd2: w_coff = 2'd2;
      4'd3: w_roff = 2'd1;
      4'd4: begin w_roff = 2'd1; w_coff = 2'd1; end
      4'd5: begin w_roff = 2'd1; w_coff = 2'd2; end
      4'd6: w_roff = 2'd2;
      4'd7: begin w_roff = 2'd2; w_coff = 2'd1; end
      4'd8: begin w_roff = 2'd2; w_coff = 2'd2; end
      default: ;
    endcase
  end

  assign w_img_addr = 16'((32'(r_row) + 32'(w_roff)) * IMG_W + 32'(r_col) + 32'(w_coff));

  // Data returned on MAC cycle k belongs to tap k-1
  assign w_kidx = (r_cnt == 4'd0) ? 4'd0 : r_cnt - 4'd1;
  assign w_pix  = $signed({1'b0, img_data});
  assign w_prod = w_pix * r_w[w_kidx];

  // ReLU plus saturation to a byte after the arithmetic shift
  assign w_sh = r_acc >>> SHIFT;
  always_comb begin
    if (w_sh[ACC_W-1])          w_clamped = 8'd0;
    else if (w_sh > CLAMP_MAX)  w_clamped = 8'hFF;
    else                        w_clamped = w_sh[7:0];
  end

  // Strobes decode from state; addresses hold their last issued value
  assign busy      = (r_state != S_IDLE);
  assign conv_done = (r_state == S_DONE);
  assign wgt_rd    = (r_state == S_LOADW) && (r_cnt < 4'd9);
  assign wgt_addr  = wgt_rd ? r_cnt : r_wgt_addr_q;
  assign img_rd    = (r_state == S_MAC) && (r_cnt < 4'd9);
  assign img_addr  = img_rd ? w_img_addr : r_img_addr_q;
  assign res_we    = (r_state == S_WRITE) ? r_ch : 3'd0;
  assign res_addr  = (r_state == S_WRITE) ? 16'(32'(r_row) * (IMG_W - 2) + 32'(r_col)) : 16'd0;
  assign res_data  = (r_state == S_WRITE) ? w_clamped : 8'd0;

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start)   w_next = S_LOADW;
      S_LOADW: if (w_cnt_end) w_next = S_MAC;
      S_MAC:   if (w_cnt_end) w_next = S_WRITE;
      S_WRITE: w_next = w_last ? S_DONE : S_MAC;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Datapath: counters, weight capture, accumulation, window stepping.
  // r_en_prev resets high so a level already present at release is not a start.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cnt        <= 4'd0;
      r_row        <= 16'd0;
      r_col        <= 16'd0;
      r_acc        <= '0;
      r_ch         <= 3'd0;
      r_en_prev    <= 1'b1;
      r_img_addr_q <= 16'd0;
      r_wgt_addr_q <= 4'd0;
      for (int i = 0; i < 9; i++) r_w[i] <= 8'sd0;
    end else begin
      r_en_prev <= |conv_en;
      case (r_state)
        S_IDLE: if (w_start) begin
          r_ch  <= conv_en[0] ? 3'b001 : (conv_en[1] ? 3'b010 : 3'b100);
          r_row <= 16'd0;
          r_col <= 16'd0;
          r_cnt <= 4'd0;
        end
        S_LOADW: begin
          if (wgt_rd)           r_wgt_addr_q <= r_cnt;
          if (r_cnt != 4'd0)    r_w[w_kidx]  <= $signed(wgt_data);
          r_cnt <= w_cnt_end ? 4'd0 : r_cnt + 4'd1;
        end
        S_MAC: begin
          if (img_rd)           r_img_addr_q <= w_img_addr;
          if (r_cnt == 4'd0)    r_acc <= '0;
          else                  r_acc <= r_acc + ACC_W'(w_prod);
          r_cnt <= w_cnt_end ? 4'd0 : r_cnt + 4'd1;
        end
        S_WRITE: begin
          r_cnt <= 4'd0;
          if (!w_last) begin
            if (r_col == 16'(IMG_W - 3)) begin
              r_col <= 16'd0;
              r_row <= r_row + 16'd1;
            end else begin
              r_col <= r_col + 16'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conv3x3_engine.sv
// Bench for conv3x3_engine on a 4x4 image (4 windows, done 55 cycles
// after the start edge). Expected results come from a reference model
// and are queued at start; the monitor pops them as the DUT writes.
module tb_conv3x3_engine;
  localparam int W = 4, H = 4;

  logic        clk = 1'b0, reset = 1'b0;
  logic [2:0]  conv_en = 3'd0;
  logic        conv_done, busy, img_rd, wgt_rd;
  logic [15:0] img_addr, res_addr;
  logic [7:0]  img_data, wgt_data, res_data;
  logic [3:0]  wgt_addr;
  logic [2:0]  res_we;

  conv3x3_engine #(.IMG_W(W), .IMG_H(H), .SHIFT(4), .ACC_W(20)) u_dut (
    .clk(clk), .reset(reset), .conv_en(conv_en), .conv_done(conv_done),
    .busy(busy), .img_addr(img_addr), .img_rd(img_rd), .img_data(img_data),
    .wgt_addr(wgt_addr), .wgt_rd(wgt_rd), .wgt_data(wgt_data),
    .res_addr(res_addr), .res_data(res_data), .res_we(res_we)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] img_mem [0:15];
  logic [7:0] wgt_mem [0:8];

  // Sync-read memories: data appears one cycle after the strobe
  always @(posedge clk) begin
    if (img_rd) img_data <= img_mem[img_addr[3:0]];
    if (wgt_rd) wgt_data <= wgt_mem[wgt_addr];
  end

  int n_vec = 0, n_err = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {int addr; int data; int we;} exp_t;
  exp_t sb[$];

  function automatic int model(input int r, input int c);
    int s = 0;
    for (int k = 0; k < 9; k++)
      s += int'(img_mem[(r + k / 3) * W + c + k % 3]) * int'($signed(wgt_mem[k]));
    s = s >>> 4;
    if (s < 0) return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  task automatic push_expected(input logic [2:0] en);
    exp_t e;
    int we;
    we = en[0] ? 1 : (en[1] ? 2 : 4);
    for (int r = 0; r < H - 2; r++)
      for (int c = 0; c < W - 2; c++) begin
        e.addr = r * (W - 2) + c;
        e.data = model(r, c);
        e.we   = we;
        sb.push_back(e);
      end
  endtask

  // Result monitor
  exp_t m;
  always @(negedge clk) begin
    if (res_we != 3'd0) begin
      if (sb.size() == 0) chk("unexpected_write", int'(res_addr), -1);
      else begin
        m = sb.pop_front();
        chk("res_addr", int'(res_addr), m.addr);
        chk("res_data", int'(res_data), m.data);
        chk("res_we",   int'(res_we),   m.we);
      end
    end
  end

  // Start a run with the given enable and follow it to the done pulse.
  // With toggle set, conv_en drops and rises on another bit mid-run.
  task automatic run(input logic [2:0] en, input bit toggle);
    int e_edge;
    bit seen;
    @(negedge clk);
    conv_en = en;
    e_edge = cyc + 1;
    push_expected(en);
    @(negedge clk);
    chk("busy_start", int'(busy), 1);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (toggle && cyc == e_edge + 20) conv_en = 3'b000;
      if (toggle && cyc == e_edge + 25) conv_en = 3'b100;
      if (conv_done) begin
        seen = 1;
        chk("done_cycle", cyc - e_edge + 1, 55);
        chk("busy_at_done", int'(busy), 1);
      end
    end
    if (!seen) chk("done_timeout", 0, 1);
    @(negedge clk);
    chk("done_pulse", int'(conv_done), 0);
    chk("busy_end", int'(busy), 0);
    chk("sb_drained", sb.size(), 0);
  endtask

  task automatic hold_check(input string tag, input int n);
    bit act = 0;
    repeat (n) begin
      @(negedge clk);
      if (busy || conv_done || img_rd || wgt_rd) act = 1;
    end
    chk(tag, int'(act), 0);
  endtask

  task automatic drop_en();
    @(negedge clk);
    conv_en = 3'd0;
    repeat (2) @(negedge clk);
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(conv_done), 0);
    chk({tag, "_rd"}, int'({img_rd, wgt_rd}), 0);
    chk({tag, "_img_addr"}, int'(img_addr), 0);
    chk({tag, "_wgt_addr"}, int'(wgt_addr), 0);
    chk({tag, "_res"}, int'({res_we, res_addr, res_data}), 0);
  endtask

  initial begin
    int e_edge;
    bit ok;
    for (int i = 0; i < 16; i++) img_mem[i] = 8'd0;
    for (int i = 0; i < 9; i++)  wgt_mem[i] = 8'd0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Uniform: 9 * 16 * 1 >>> 4 = 9
    for (int i = 0; i < 16; i++) img_mem[i] = 8'd16;
    for (int i = 0; i < 9; i++)  wgt_mem[i] = 8'd1;
    run(3'b001, 0);
    drop_en();

    // Center tap with weight 16 cancels the shift: result = pixel address
    // 5,6,9,10. Channel 110 picks bit 1; held level must not restart.
    for (int i = 0; i < 16; i++) img_mem[i] = 8'(i);
    for (int i = 0; i < 9; i++)  wgt_mem[i] = 8'd0;
    wgt_mem[4] = 8'd16;
    run(3'b110, 0);
    hold_check("no_restart_held", 30);
    drop_en();

    // Saturation high, with a mid-run drop/rise on conv_en
    for (int i = 0; i < 16; i++) img_mem[i] = 8'd255;
    for (int i = 0; i < 9; i++)  wgt_mem[i] = 8'd127;
    run(3'b001, 1);
    hold_check("no_restart_after_toggle", 30);
    drop_en();

    // Negative sums clamp to zero
    for (int i = 0; i < 16; i++) img_mem[i] = 8'($urandom_range(1, 255));
    for (int i = 0; i < 9; i++)  wgt_mem[i] = 8'hFF;
    run(3'b100, 0);
    drop_en();

    // Mixed-sign random weights
    for (int t = 0; t < 3; t++) begin
      for (int i = 0; i < 16; i++) img_mem[i] = 8'($urandom_range(0, 255));
      for (int i = 0; i < 9; i++)  wgt_mem[i] = 8'($signed($urandom_range(0, 8)) - 4);
      run(3'b001, 0);
      drop_en();
    end

    // Reset in the middle of window 1's MAC
    for (int i = 0; i < 16; i++) img_mem[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 9; i++)  wgt_mem[i] = 8'($urandom_range(0, 3));
    @(negedge clk);
    conv_en = 3'b001;
    e_edge = cyc + 1;
    push_expected(3'b001);
    ok = 0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk);
      if (cyc == e_edge + 29) ok = 1;
    end
    chk("reach_mid_mac", int'(ok), 1);
    chk("busy_mid_mac", int'(busy), 1);
    reset = 1'b0;
    #1;
    check_idle_outputs("midreset");
    chk("one_window_written", sb.size(), 3);
    sb.delete();
    repeat (2) @(negedge clk);
    reset = 1'b1;
    hold_check("no_start_level_at_release", 20);
    drop_en();
    run(3'b001, 0);
    drop_en();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

endmodule
